// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, baud divisors and config decode helpers
package uart_pkg;
  typedef enum logic [1:0] {NONE, EVEN, ODD} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int BAUD_4800   = 4800;
  localparam int BAUD_9600   = 9600;
  localparam int BAUD_115200 = 115200;
  localparam int BAUD_256000 = 256000;
  function automatic int baud_of(logic [3:0] mode);
    return mode == 4'd0 ? BAUD_4800 : mode == 4'd2 ? BAUD_115200 : mode == 4'd3 ? BAUD_256000 : BAUD_9600;
  endfunction
  // Rounded clocks per bit.
  function automatic int len_bit(int clk_freq, logic [3:0] mode);
    return (clk_freq + baud_of(mode) / 2) / baud_of(mode);
  endfunction
  function automatic logic [3:0] n_bits(logic [1:0] data_bits);
    return 4'd5 + {2'b00, data_bits};
  endfunction
endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: received-frame handshake; master = receiver, slave = consumer
interface uart_rx_cfg_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  modport master (output data, data_valid, parity_err, frame_err, overrun, input data_ack);
  modport slave  (input data, data_valid, parity_err, frame_err, overrun, output data_ack);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: preset-high synchroniser chain with falling-edge detect (clk, rst, d -> q, fall)
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic              prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '1;
      prev <= 1'b1;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end
  assign q    = sr[STAGES-1];
  assign fall = prev & ~q;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (5-8 bits, none/even/odd parity, 1/2 stop)
// Ports: clk, rst, rx_line (async, idle high), mode/data_bits/parity/stop2 config, rx (uart_rx_cfg_if.master).
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_line,
  input  logic [3:0]    mode,
  input  logic [1:0]    data_bits,
  input  logic [1:0]    parity,
  input  logic          stop2,
  uart_rx_cfg_if.master rx
);
  localparam logic [31:0] L0 = 32'(len_bit(CLK_FREQ, 4'd0));
  localparam logic [31:0] L1 = 32'(len_bit(CLK_FREQ, 4'd1));
  localparam logic [31:0] L2 = 32'(len_bit(CLK_FREQ, 4'd2));
  localparam logic [31:0] L3 = 32'(len_bit(CLK_FREQ, 4'd3));
  logic        line, fall, hit, s, stop2_q, stop_idx, perr, ferr;
  logic [31:0] cnt, len_q, tgt, cnt_rst;
  logic [2:0]  idx;
  logic [3:0]  nb_q;
  logic [7:0]  data_r;
  parity_e     par_q;
  rx_state_e   state;
  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(rx_line), .q(line), .fall(fall));
  assign tgt = state == START ? (len_q >> 1) - 32'd1 : len_q - 32'd1;
`ifdef UART_RX_MAJORITY_EN
  // Vote closes one cycle past the target; restarting at 1 keeps the bit period intact.
  logic [1:0] win;
  always_ff @(posedge clk) begin
    if (rst) win <= 2'b11;
    else if (cnt == tgt - 32'd1 || cnt == tgt) win <= {win[0], line};
  end
  assign hit     = cnt == tgt + 32'd1;
  assign s       = (win[1] & win[0]) | (win[1] & line) | (win[0] & line);
  assign cnt_rst = 32'd1;
`else
  assign hit     = cnt == tgt;
  assign s       = line;
  assign cnt_rst = 32'd0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      len_q         <= '0;
      idx           <= '0;
      nb_q          <= '0;
      par_q         <= NONE;
      stop2_q       <= 1'b0;
      stop_idx      <= 1'b0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      data_r        <= '0;
      rx.data       <= '0;
      rx.data_valid <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      cnt           <= cnt + 32'd1;
      rx.data_valid <= rx.data_ack ? 1'b0 : rx.data_valid;
      rx.overrun    <= rx.data_ack ? 1'b0 : rx.overrun;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state    <= START;
            len_q    <= mode == 4'd0 ? L0 : mode == 4'd2 ? L2 : mode == 4'd3 ? L3 : L1;
            nb_q     <= n_bits(data_bits);
            par_q    <= parity == 2'd3 ? NONE : parity_e'(parity);
            stop2_q  <= stop2;
            idx      <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            data_r   <= '0;
          end
        end
        START: if (hit) begin
          state <= s ? IDLE : DATA;
          cnt   <= cnt_rst;
        end
        DATA: if (hit) begin
          data_r[idx] <= s;
          idx         <= idx + 3'd1;
          cnt         <= cnt_rst;
          if ({1'b0, idx} == nb_q - 4'd1) state <= par_q == NONE ? STOP : PARITY;
        end
        PARITY: if (hit) begin
          perr  <= (^data_r ^ s) != (par_q == ODD);
          state <= STOP;
          cnt   <= cnt_rst;
        end
        STOP: if (hit) begin
          cnt      <= cnt_rst;
          stop_idx <= 1'b1;
          ferr     <= ferr | ~s;
          if (stop_idx == stop2_q) begin
            state         <= IDLE;
            rx.data       <= data_r;
            rx.parity_err <= perr;
            rx.frame_err  <= ferr | ~s;
            rx.data_valid <= 1'b1;
            if (rx.data_valid && !rx.data_ack) rx.overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
